text_render_ctrl: RTL and testbench

TEXT_RENDER_CTRL -- requirements
Module: text_render_ctrl

---
 rtl/text_render_ctrl.sv | 137 +++++++++++++
 tb/tb_text_render_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_render_ctrl.sv
// Character-cell text renderer: pixel coordinates in, rendered pixel out,
// fixed 3-clock pipeline (text RAM lookup, font ROM lookup, output register)
// with a blinking block cursor driven by a vsync-edge frame counter.
module text_render_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [9:0]  i_px,
  input  logic [9:0]  i_py,
  input  logic        i_de,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic [12:0] o_txt_addr,
  input  logic [7:0]  i_txt_data,
  output logic [10:0] o_font_addr,
  output logic [2:0]  o_font_bit,
  input  logic        i_font_data,
  input  logic [6:0]  i_cur_col,
  input  logic [5:0]  i_cur_row,
  input  logic        i_cur_en,
  output logic        o_pix,
  output logic        o_de,
  output logic        o_hs,
  output logic        o_vs
);

  localparam logic [10:0] X_LIM = 11'(COLS * 8);
  localparam logic [10:0] Y_LIM = 11'(ROWS * 8);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } timing_t;

  typedef struct packed {
    logic [2:0] px;
    logic [2:0] py;
    logic       in_range;
    logic       hit;
    timing_t    tim;
  } stage1_t;

  typedef struct packed {
    logic    in_range;
    logic    hit;
    timing_t tim;
  } stage2_t;

  stage1_t          s1_q, s1_d;
  stage2_t          s2_q, s2_d;
  timing_t          tim3_q, tim3_d;
  logic             pix_q, pix_d;
  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_on_q, blink_on_d;

  logic in_range0;
  logic hit0;

  // Stage 0: range test, cursor hit and text RAM address from raw coordinates
  always_comb begin
    in_range0 = ({1'b0, i_px} < X_LIM) && ({1'b0, i_py} < Y_LIM);
    hit0      = i_cur_en && (i_px[9:3] == i_cur_col) && (i_py[9:3] == {1'b0, i_cur_row});
    if (in_range0) begin
      o_txt_addr = 13'(i_py[9:3]) * 13'(COLS) + 13'(i_px[9:3]);
    end else begin
      o_txt_addr = '0;
    end
  end

  // Font ROM request: character from text RAM paired with the stage-1 cell offsets
  always_comb begin
    o_font_addr = {i_txt_data, s1_q.py};
    o_font_bit  = 3'd7 - s1_q.px;
  end

  // Next-state for the pixel pipeline, vsync edge detector and blink counter
  always_comb begin
    s1_d.px       = i_px[2:0];
    s1_d.py       = i_py[2:0];
    s1_d.in_range = in_range0;
    s1_d.hit      = hit0;
    s1_d.tim      = '{de: i_de, hs: i_hs, vs: i_vs};

    s2_d.in_range = s1_q.in_range;
    s2_d.hit      = s1_q.hit;
    s2_d.tim      = s1_q.tim;

    tim3_d = s2_q.tim;
    pix_d  = s2_q.tim.de & s2_q.in_range & (i_font_data ^ (s2_q.hit & blink_on_q));

    vs_prev_d   = i_vs;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (i_vs && !vs_prev_q) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // State registers; blink starts in the visible (inverting) phase
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_q        <= '0;
      s2_q        <= '0;
      tim3_q      <= '0;
      pix_q       <= 1'b0;
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      tim3_q      <= tim3_d;
      pix_q       <= pix_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign o_pix = pix_q;
  assign o_de  = tim3_q.de;
  assign o_hs  = tim3_q.hs;
  assign o_vs  = tim3_q.vs;

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl with behavioural text RAM and font ROM.
module tb_text_render_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  px, py;
  logic        de, hs, vs;
  logic [12:0] txt_addr;
  logic [7:0]  txt_data;
  logic [10:0] font_addr;
  logic [2:0]  font_bit;
  logic        font_data;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic        cur_en;
  logic        o_pix, o_de, o_hs, o_vs;

  logic [7:0] tram [0:8191];
  logic [7:0] font [0:2047];

  int n_pass  = 0;
  int n_total = 0;

  text_render_ctrl #(.COLS(80), .ROWS(60), .BLINK_FRAMES(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_px(px), .i_py(py),
    .i_de(de), .i_hs(hs), .i_vs(vs),
    .o_txt_addr(txt_addr), .i_txt_data(txt_data),
    .o_font_addr(font_addr), .o_font_bit(font_bit), .i_font_data(font_data),
    .i_cur_col(cur_col), .i_cur_row(cur_row), .i_cur_en(cur_en),
    .o_pix(o_pix), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data valid one clock after address
  always @(posedge clk) begin
    txt_data  <= tram[txt_addr];
    font_data <= font[font_addr][font_bit];
  end

  typedef struct {
    logic [9:0]  px, py;
    logic        de, hs, en;
    logic [6:0]  col;
    logic [5:0]  row;
    logic [12:0] addr;
    logic [10:0] faddr;
    logic [2:0]  fbit;
    logic        pix;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int x, y, d, h, en, col, row, addr, faddr, fbit, pix);
    vec_t v;
    v.px = 10'(x); v.py = 10'(y); v.de = 1'(d); v.hs = 1'(h); v.en = 1'(en);
    v.col = 7'(col); v.row = 6'(row); v.addr = 13'(addr); v.faddr = 11'(faddr);
    v.fbit = 3'(fbit); v.pix = 1'(pix);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] x, y, input logic d, h, v);
    px = x; py = y; de = d; hs = h; vs = v;
  endtask

  task automatic cursor(input logic en, input logic [6:0] col, input logic [5:0] row);
    cur_en = en; cur_col = col; cur_row = row;
  endtask

  // Present one cursor-cell pixel (font all zero) and check the rendered result
  task automatic blink_probe(input logic exp, input string nm);
    drive(10'd16, 10'd8, 1'b1, 1'b0, 1'b0);
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check(nm, 32'(o_pix), 32'(exp));
  endtask

  task automatic vs_pulse(input int hi);
    for (int k = 0; k < hi; k++) begin
      drive(10'd700, 10'd500, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pd, ph, pv;
    logic [7:0]  rp;
    int n;

    for (int i = 0; i < 8192; i++) tram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    tram[0]    = 8'h41;
    tram[4799] = 8'h41;
    font[11'h208] = 8'b0011_1100;
    font[11'h209] = 8'b1000_0001;
    font[11'h20F] = 8'b0000_0001;
    txt_data  = 8'h00;
    font_data = 1'b0;

    // Reset with active-looking inputs: outputs must stay low
    rstn = 1'b0;
    cursor(1'b0, '0, '0);
    drive(10'd5, 10'd5, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("rst_pix", 32'(o_pix), 0);
    check("rst_de",  32'(o_de),  0);
    check("rst_hs",  32'(o_hs),  0);
    check("rst_vs",  32'(o_vs),  0);
    check("rst_blink", 32'(dut.blink_on_q), 1);
    check("rst_fcnt",  32'(dut.frame_cnt_q), 0);
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();

    // x, y, de, hs, cur_en, col, row, addr, font_addr, font_bit, pix
    for (int i = 0; i < 8; i++) begin
      rp = 8'b0011_1100;
      vecs.push_back(mk(i, 0, 1, i % 2, 0, 0, 0, 0, 'h208, 7 - i, rp[7 - i]));
    end
    vecs.push_back(mk(0,   1,   1, 0, 0, 0, 0, 0,    'h209, 7, 1));
    vecs.push_back(mk(1,   1,   1, 1, 0, 0, 0, 0,    'h209, 6, 0));
    vecs.push_back(mk(7,   1,   1, 0, 0, 0, 0, 0,    'h209, 0, 1));
    vecs.push_back(mk(639, 479, 1, 1, 0, 0, 0, 4799, 'h20F, 0, 1));
    vecs.push_back(mk(640, 0,   1, 0, 0, 0, 0, 0,    'h208, 7, 0));
    vecs.push_back(mk(642, 0,   1, 1, 0, 0, 0, 0,    'h208, 5, 0));
    vecs.push_back(mk(2,   480, 1, 0, 0, 0, 0, 0,    'h208, 5, 0));
    vecs.push_back(mk(2,   0,   0, 1, 0, 0, 0, 0,    'h208, 5, 0));
    vecs.push_back(mk(15,  8,   1, 0, 1, 2, 1, 81,   'h000, 0, 0));
    vecs.push_back(mk(16,  8,   1, 0, 1, 2, 1, 82,   'h000, 7, 1));
    vecs.push_back(mk(23,  8,   1, 1, 1, 2, 1, 82,   'h000, 0, 1));
    vecs.push_back(mk(24,  8,   1, 0, 1, 2, 1, 83,   'h000, 7, 0));
    vecs.push_back(mk(16,  15,  1, 0, 1, 2, 1, 82,   'h007, 7, 1));
    vecs.push_back(mk(20,  16,  1, 1, 1, 2, 1, 162,  'h000, 3, 0));
    vecs.push_back(mk(16,  7,   1, 0, 1, 2, 1, 2,    'h007, 7, 0));
    vecs.push_back(mk(16,  8,   0, 0, 1, 2, 1, 82,   'h000, 7, 0));
    vecs.push_back(mk(16,  8,   1, 0, 0, 2, 1, 82,   'h000, 7, 0));
    vecs.push_back(mk(2,   0,   1, 0, 1, 0, 0, 0,    'h208, 5, 0));
    vecs.push_back(mk(0,   0,   1, 1, 1, 0, 0, 0,    'h208, 7, 1));
    vecs.push_back(mk(639, 479, 1, 0, 1, 79, 59, 4799, 'h20F, 0, 0));
    vecs.push_back(mk(640, 0,   1, 0, 1, 80, 0, 0,   'h208, 7, 0));

    n = vecs.size();
    for (int i = 0; i < n + 3; i++) begin
      if (i >= 1 && i - 1 < n) begin
        check($sformatf("vec%0d_faddr", i - 1), 32'(font_addr), 32'(vecs[i-1].faddr));
        check($sformatf("vec%0d_fbit", i - 1),  32'(font_bit),  32'(vecs[i-1].fbit));
      end
      if (i >= 3) begin
        check($sformatf("vec%0d_pix", i - 3), 32'(o_pix), 32'(vecs[i-3].pix));
        check($sformatf("vec%0d_tim", i - 3), 32'({o_de, o_hs, o_vs}),
              32'({vecs[i-3].de, vecs[i-3].hs, 1'b0}));
      end
      if (i < n) begin
        cursor(vecs[i].en, vecs[i].col, vecs[i].row);
        drive(vecs[i].px, vecs[i].py, vecs[i].de, vecs[i].hs, 1'b0);
      end else begin
        cursor(1'b0, '0, '0);
        drive('0, '0, 1'b0, 1'b0, 1'b0);
      end
      #1;
      if (i < n) check($sformatf("vec%0d_addr", i), 32'(txt_addr), 32'(vecs[i].addr));
      @(posedge clk);
      #1;
    end

    // Arbitrary timing pattern, three vsync rises: delayed copy on the outputs
    pd = 24'hA5C396;
    ph = 24'h3C0F5A;
    pv = '0;
    pv[4:2]   = '1;
    pv[15:10] = '1;
    pv[21:20] = '1;
    for (int i = 0; i < 27; i++) begin
      if (i >= 3)
        check($sformatf("timing%0d", i - 3), 32'({o_de, o_hs, o_vs}),
              32'({pd[i-3], ph[i-3], pv[i-3]}));
      if (i < 24) drive(10'd700, 10'd500, pd[i], ph[i], pv[i]);
      else        drive('0, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("pre_rst_blink", 32'(dut.blink_on_q), 0);
    check("pre_rst_fcnt",  32'(dut.frame_cnt_q), 1);

    // Mid-line reset pulse
    for (int k = 0; k < 5; k++) begin
      drive(10'(k), 10'd0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    check("pre_rst_de", 32'(o_de), 1);
    rstn = 1'b0;
    #1;
    check("midrst_out", 32'({o_pix, o_de, o_hs, o_vs}), 0);
    check("midrst_blink", 32'(dut.blink_on_q), 1);
    check("midrst_fcnt",  32'(dut.frame_cnt_q), 0);
    @(posedge clk);
    #1;
    check("midrst_hold", 32'({o_pix, o_de, o_hs, o_vs}), 0);
    rstn = 1'b1;
    rp = 8'b0011_1100;
    for (int i = 0; i < 11; i++) begin
      if (i < 3) check($sformatf("post_rst_de%0d", i), 32'(o_de), 0);
      else       check($sformatf("post_rst_pix%0d", i - 3), 32'(o_pix), 32'(rp[7 - (i - 3)]));
      if (i < 8) drive(10'(i), 10'd0, 1'b1, 1'b0, 1'b0);
      else       drive('0, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Cursor blink with two frames per half-period
    cursor(1'b1, 7'd2, 6'd1);
    blink_probe(1'b1, "blink_f1");
    vs_pulse(3);
    blink_probe(1'b1, "blink_f2");
    vs_pulse(3);
    blink_probe(1'b0, "blink_f3");
    vs_pulse(3);
    blink_probe(1'b0, "blink_f4");
    vs_pulse(3);
    blink_probe(1'b1, "blink_f5");
    vs_pulse(40);
    blink_probe(1'b1, "blink_long_vs");
    vs_pulse(3);
    blink_probe(1'b0, "blink_after_long");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
